// File: rtl/prime_bound_finder_if.sv
// Request/result bundle for prime_bound_finder. Carries in_prime only when
// PRIME_SELF_TEST_EN is defined.
interface prime_bound_finder_if #(
  parameter int WIDTH = 14
);
  logic             give_valid;
  logic [WIDTH-1:0] Intake;
  logic             busy;
  logic [WIDTH-1:0] UpPrime;
  logic [WIDTH-1:0] LowPrime;
  logic             up_none;
  logic             low_none;
  logic             out_valid;
`ifdef PRIME_SELF_TEST_EN
  logic             in_prime;

  modport master (
    output give_valid, Intake,
    input  busy, UpPrime, LowPrime, up_none, low_none, out_valid, in_prime
  );
  modport slave (
    input  give_valid, Intake,
    output busy, UpPrime, LowPrime, up_none, low_none, out_valid, in_prime
  );
`else
  modport master (
    output give_valid, Intake,
    input  busy, UpPrime, LowPrime, up_none, low_none, out_valid
  );
  modport slave (
    input  give_valid, Intake,
    output busy, UpPrime, LowPrime, up_none, low_none, out_valid
  );
`endif
endinterface

// File: rtl/prime_bound_finder.sv
// Trial-division search for the nearest primes below and above an accepted N.
// Optional macro PRIME_SELF_TEST_EN adds an N_TEST phase and the in_prime result.
module prime_bound_finder #(
  parameter int WIDTH = 14
) (
  input logic                 clk,
  input logic                 reset,
  prime_bound_finder_if.slave bus
);
  localparam int DW = WIDTH / 2 + 2;
  localparam logic [WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);
  localparam logic [DW-1:0]    DIV_INIT = DW'(2);

`ifdef PRIME_SELF_TEST_EN
  typedef enum logic [2:0] {IDLE, N_TEST, LOW_TEST, UP_TEST, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOW_TEST, UP_TEST, DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [DW-1:0]    div_q, div_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] up_q, up_d;
  logic             low_none_q, low_none_d;
  logic             up_none_q, up_none_d;
`ifdef PRIME_SELF_TEST_EN
  logic             in_prime_q, in_prime_d;
`endif

  // One divisor is evaluated per cycle against the current candidate.
  logic [2*DW-1:0]  div_ext;
  logic [2*DW-1:0]  div_sq;
  logic             root_passed;
  logic             divides;
  logic [DW-1:0]    div_step;

  assign div_ext     = (2*DW)'(div_q);
  assign div_sq      = div_ext * div_ext;
  assign root_passed = div_sq > (2*DW)'(cand_q);
  assign divides     = (cand_q % WIDTH'(div_q)) == '0;
  assign div_step    = (div_q == DIV_INIT) ? DW'(3) : div_q + DW'(2);

  logic             go_low;
  logic             go_up;
  logic [WIDTH-1:0] base;

  always_comb begin
    // NOTE: every variable gets a default here so no path can infer a latch.
    state_d    = state_q;
    num_d      = num_q;
    cand_d     = cand_q;
    div_d      = div_q;
    low_d      = low_q;
    up_d       = up_q;
    low_none_d = low_none_q;
    up_none_d  = up_none_q;
`ifdef PRIME_SELF_TEST_EN
    in_prime_d = in_prime_q;
`endif
    go_low     = 1'b0;
    go_up      = 1'b0;
    base       = num_q;

    case (state_q)
      IDLE: begin
        if (bus.give_valid) begin
          num_d      = bus.Intake;
          base       = bus.Intake;
          low_d      = '0;
          up_d       = '0;
          low_none_d = 1'b0;
          up_none_d  = 1'b0;
`ifdef PRIME_SELF_TEST_EN
          in_prime_d = 1'b0;
          cand_d     = bus.Intake;
          div_d      = DIV_INIT;
          state_d    = N_TEST;
`else
          go_low     = 1'b1;
`endif
        end
      end
`ifdef PRIME_SELF_TEST_EN
      N_TEST: begin
        if (cand_q < TWO) begin
          go_low = 1'b1;
        end else if (root_passed) begin
          in_prime_d = 1'b1;
          go_low     = 1'b1;
        end else if (divides) begin
          go_low = 1'b1;
        end else begin
          div_d = div_step;
        end
      end
`endif
      LOW_TEST: begin
        if (cand_q < TWO) begin
          low_none_d = 1'b1;
          low_d      = '0;
          go_up      = 1'b1;
        end else if (root_passed) begin
          low_d = cand_q;
          go_up = 1'b1;
        end else if (divides) begin
          cand_d = cand_q - ONE;
          div_d  = DIV_INIT;
        end else begin
          div_d = div_step;
        end
      end
      UP_TEST: begin
        // 0 and 1 are never prime; without this guard 1 would pass the root test.
        if (cand_q < TWO) begin
          cand_d = cand_q + ONE;
          div_d  = DIV_INIT;
        end else if (root_passed) begin
          up_d    = cand_q;
          state_d = DONE;
        end else if (divides) begin
          if (cand_q == MAX_VAL) begin
            up_none_d = 1'b1;
            up_d      = '0;
            state_d   = DONE;
          end else begin
            cand_d = cand_q + ONE;
            div_d  = DIV_INIT;
          end
        end else begin
          div_d = div_step;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Phase setup is shared by every path that starts the downward or upward search.
    if (go_low) begin
      if (base <= TWO) begin
        low_none_d = 1'b1;
        low_d      = '0;
        go_up      = 1'b1;
      end else begin
        cand_d  = base - ONE;
        div_d   = DIV_INIT;
        state_d = LOW_TEST;
      end
    end
    if (go_up) begin
      if (base == MAX_VAL) begin
        up_none_d = 1'b1;
        up_d      = '0;
        state_d   = DONE;
      end else begin
        cand_d  = base + ONE;
        div_d   = DIV_INIT;
        state_d = UP_TEST;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (reset) begin
      state_q    <= IDLE;
      num_q      <= '0;
      cand_q     <= '0;
      div_q      <= DIV_INIT;
      low_q      <= '0;
      up_q       <= '0;
      low_none_q <= 1'b0;
      up_none_q  <= 1'b0;
`ifdef PRIME_SELF_TEST_EN
      in_prime_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      cand_q     <= cand_d;
      div_q      <= div_d;
      low_q      <= low_d;
      up_q       <= up_d;
      low_none_q <= low_none_d;
      up_none_q  <= up_none_d;
`ifdef PRIME_SELF_TEST_EN
      in_prime_q <= in_prime_d;
`endif
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.LowPrime  = low_q;
  assign bus.UpPrime   = up_q;
  assign bus.low_none  = low_none_q;
  assign bus.up_none   = up_none_q;
`ifdef PRIME_SELF_TEST_EN
  assign bus.in_prime  = in_prime_q;
`endif
endmodule
